// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// master is the fetch unit; slave is the memory/decode/control side.
interface fetch_unit_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic [ADDR_W-1:0]  id_pc_plus1;
    logic               halted;
    logic [15:0]        fetch_count;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, halted, fetch_count,
        input  imem_instr, redirect, redirect_pc, halt, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, halted, fetch_count,
        output imem_instr, redirect, redirect_pc, halt, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fills a one-entry IF/ID slot from a
// combinational instruction memory, handles redirect/flush, halt and a delivery counter.
module fetch_unit #(
    parameter int                ADDR_W   = 6,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic [ADDR_W-1:0]  slot_pc, slot_pc_next;
    logic [INSTR_W-1:0] slot_instr, slot_instr_next;
    logic               slot_valid, slot_valid_next;
    logic [15:0]        count;
    logic               fire;
    logic               can_load;

    assign fire     = slot_valid & bus.id_ready;
    assign can_load = (state == RUN) & (~slot_valid | bus.id_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            slot_pc    <= '0;
            slot_instr <= '0;
            slot_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            slot_pc    <= slot_pc_next;
            slot_instr <= slot_instr_next;
            slot_valid <= slot_valid_next;
        end
    end

    // Redirect beats halt beats a normal load; anything else is a stall or a drain.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        slot_pc_next    = slot_pc;
        slot_instr_next = slot_instr;
        slot_valid_next = slot_valid;

        if (bus.redirect) begin
            pc_next         = bus.redirect_pc;
            slot_valid_next = 1'b0;
            state_next      = RUN;
        end else if (state == RUN && bus.halt) begin
            state_next = HALTED;
            if (fire) begin
                slot_valid_next = 1'b0;
            end
        end else if (can_load) begin
            slot_instr_next = bus.imem_instr;
            slot_pc_next    = pc;
            slot_valid_next = 1'b1;
            pc_next         = pc + ADDR_W'(1);
        end else if (fire) begin
            slot_valid_next = 1'b0;
        end
    end

    // Counts every handshake, a flushed one included, and sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (fire && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = slot_valid;
    assign bus.id_instr    = slot_instr;
    assign bus.id_pc       = slot_pc;
    assign bus.id_pc_plus1 = slot_pc + ADDR_W'(1);
    assign bus.halted      = (state == HALTED);
    assign bus.fetch_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based slot model is checked every cycle,
// and literal expectations at key points pin the model itself.
module tb_fetch_unit;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 64;

    typedef struct {
        logic [31:0] instr;
        int          pc;
    } entry_t;

    logic clk;
    logic rst_n;
    logic [31:0] mem [DEPTH];

    int tests;
    int fails;

    entry_t      slot[$];
    int          mPc;
    bit          mHalted;
    int          mCount;
    logic [31:0] heldInstr;
    int          heldPc;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(6'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [5:0] target,
                                 input logic hlt, input int cycles);
        bus.id_ready    = ready;
        bus.redirect    = redir;
        bus.redirect_pc = target;
        bus.halt        = hlt;
        repeat (cycles) @(negedge clk);
        bus.redirect = 1'b0;
        bus.halt     = 1'b0;
    endtask

    // Model: the slot is a queue of at most one entry; consumption happens before refill.
    always @(posedge clk or negedge rst_n) begin
        bit consumed;
        if (!rst_n) begin
            slot.delete();
            mPc       = 0;
            mHalted   = 1'b0;
            mCount    = 0;
            heldInstr = '0;
            heldPc    = 0;
        end else begin
            consumed = (slot.size() != 0) && (bus.id_ready === 1'b1);
            if (consumed) begin
                void'(slot.pop_front());
                if (mCount < 65535) mCount++;
            end
            if (bus.redirect) begin
                slot.delete();
                mPc     = int'(bus.redirect_pc);
                mHalted = 1'b0;
            end else if (!mHalted && bus.halt) begin
                mHalted = 1'b1;
            end else if (!mHalted && slot.size() == 0) begin
                slot.push_back('{instr: mem[mPc], pc: mPc});
                heldInstr = mem[mPc];
                heldPc    = mPc;
                mPc       = (mPc + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("imem_addr",   32'(bus.imem_addr),   32'(mPc));
        checkOutput("id_valid",    32'(bus.id_valid),    32'(slot.size() != 0));
        checkOutput("id_instr",    bus.id_instr,         heldInstr);
        checkOutput("id_pc",       32'(bus.id_pc),       32'(heldPc));
        checkOutput("id_pc_plus1", 32'(bus.id_pc_plus1), 32'((heldPc + 1) % DEPTH));
        checkOutput("halted",      32'(bus.halted),      32'(mHalted));
        checkOutput("fetch_count", 32'(bus.fetch_count), 32'(mCount));
    end

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
        rst_n           = 1'b0;
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst id_valid", 32'(bus.id_valid), 32'd0);
        checkOutput("rst imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst id_instr", bus.id_instr, 32'd0);
        checkOutput("rst count", 32'(bus.fetch_count), 32'd0);
        checkOutput("rst halted", 32'(bus.halted), 32'd0);

        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("first instr", bus.id_instr, 32'h1000_0000);
        checkOutput("first plus1", 32'(bus.id_pc_plus1), 32'd1);
        checkOutput("first count", 32'(bus.fetch_count), 32'd0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("second instr", bus.id_instr, 32'h1000_0001);
        checkOutput("second count", 32'(bus.fetch_count), 32'd1);
        applyStimulus(1, 0, 0, 0, 4);
        checkOutput("stream id_pc", 32'(bus.id_pc), 32'd5);

        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("stall id_pc", 32'(bus.id_pc), 32'd5);
        checkOutput("stall pc", 32'(bus.imem_addr), 32'd6);
        checkOutput("stall count", 32'(bus.fetch_count), 32'd5);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("unstall id_pc", 32'(bus.id_pc), 32'd6);
        applyStimulus(1, 0, 0, 0, 6);
        checkOutput("pre-redir id_pc", 32'(bus.id_pc), 32'd12);

        applyStimulus(0, 1, 40, 0, 1);
        checkOutput("flush valid", 32'(bus.id_valid), 32'd0);
        checkOutput("redir pc", 32'(bus.imem_addr), 32'd40);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("target instr", bus.id_instr, 32'h1000_0028);
        checkOutput("flush not counted", 32'(bus.fetch_count), 32'd12);
        applyStimulus(1, 0, 0, 0, 1);

        applyStimulus(1, 1, 62, 0, 1);
        checkOutput("redir fire count", 32'(bus.fetch_count), 32'd14);
        applyStimulus(1, 0, 0, 0, 2);
        checkOutput("wrap id_pc 63", 32'(bus.id_pc), 32'd63);
        checkOutput("wrap plus1", 32'(bus.id_pc_plus1), 32'd0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("wrap id_pc 0", 32'(bus.id_pc), 32'd0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("wrap id_pc 1", 32'(bus.id_pc), 32'd1);

        applyStimulus(1, 1, 7, 0, 1);
        applyStimulus(1, 0, 0, 0, 2);
        checkOutput("pre-halt id_pc", 32'(bus.id_pc), 32'd8);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("halted", 32'(bus.halted), 32'd1);
        checkOutput("halt drain", 32'(bus.id_valid), 32'd0);
        applyStimulus(1, 0, 0, 1, 2);
        checkOutput("halt pc", 32'(bus.imem_addr), 32'd9);
        checkOutput("halt count", 32'(bus.fetch_count), 32'd20);
        applyStimulus(1, 1, 3, 0, 1);
        checkOutput("unhalt", 32'(bus.halted), 32'd0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("unhalt id_pc", 32'(bus.id_pc), 32'd3);

        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("halt held valid", 32'(bus.id_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("halted drain", 32'(bus.id_valid), 32'd0);
        checkOutput("halted drain count", 32'(bus.fetch_count), 32'd21);

        applyStimulus(1, 1, 20, 1, 1);
        checkOutput("redir+halt halted", 32'(bus.halted), 32'd0);
        checkOutput("redir+halt pc", 32'(bus.imem_addr), 32'd20);
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(1, 1, 30, 1, 1);
        checkOutput("run redir+halt", 32'(bus.halted), 32'd0);
        checkOutput("run redir+halt count", 32'(bus.fetch_count), 32'd23);

        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async valid", 32'(bus.id_valid), 32'd0);
        checkOutput("async pc", 32'(bus.imem_addr), 32'd0);
        checkOutput("async count", 32'(bus.fetch_count), 32'd0);
        checkOutput("async id_pc", 32'(bus.id_pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("resume instr", bus.id_instr, 32'h1000_0000);

        applyStimulus(1, 0, 0, 0, 65540);
        checkOutput("saturate", 32'(bus.fetch_count), 32'h0000_FFFF);
        applyStimulus(1, 0, 0, 0, 2);
        checkOutput("saturate hold", 32'(bus.fetch_count), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
